// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state type and the burst next-address helper
// used by the RAM-backed AXI3 slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, WB} state_e;

  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [3:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    // Wrap boundary spans the whole burst: (len+1) beats of 2^size bytes.
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI3 read/write channel bundle between the CPU master and the RAM slave.
interface axi_ram_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_ram_bytewe.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// one-cycle registered read. Each byte lane is its own array.
module axi_ram_bytewe #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [0:(1<<MEM_AW)-1];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) mem_q[addr] <= wdata[8*gi +: 8];
          rd_q <= mem_q[addr];
        end
      end
      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate
endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave serving one read or write burst at a time from on-chip RAM,
// with round-robin arbitration between simultaneous AR and AW requests.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int ID_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  axi_ram_slave_if.slave s
);
  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [3:0]      beat_q, beat_d;
  logic            err_q, err_d;
  logic            werr_q, werr_d;
  logic            over_q, over_d;

  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic        unused_bits;

  assign unused_bits = ^{s.wid, s.arlen[7:4], s.awlen[7:4]};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    werr_d  = werr_q;
    over_d  = over_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    bvalid  = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 4'b0000;
    case (state_q)
      IDLE: begin
        arready = s.arvalid && (!s.awvalid || !rr_q);
        awready = s.awvalid && (!s.arvalid || rr_q);
        if (arready) begin
          id_d    = s.arid;
          addr_d  = s.araddr;
          len_d   = s.arlen[3:0];
          size_d  = s.arsize;
          burst_d = s.arburst;
          err_d   = (s.arburst == 2'b11) || (s.arsize > 3'd2);
          beat_d  = 4'd0;
          rr_d    = 1'b1;
          state_d = RD_REQ;
        end else if (awready) begin
          id_d    = s.awid;
          addr_d  = s.awaddr;
          len_d   = s.awlen[3:0];
          size_d  = s.awsize;
          burst_d = s.awburst;
          err_d   = (s.awburst == 2'b11) || (s.awsize > 3'd2);
          beat_d  = 4'd0;
          werr_d  = 1'b0;
          over_d  = 1'b0;
          rr_d    = 1'b0;
          state_d = WR;
        end
      end
      RD_REQ: begin
        ram_en  = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rlast  = (beat_q == len_q);
        if (s.rready) begin
          if (rlast) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
            beat_d  = beat_q + 4'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR: begin
        wready = 1'b1;
        if (s.wvalid) begin
          ram_en = !err_q && !over_q;
          ram_we = ram_en ? s.wstrb : 4'b0000;
          addr_d = next_addr(addr_q, len_q, size_q, burst_q);
          beat_d = beat_q + 4'd1;
          // Once the last legal beat passes without wlast, the rest are dropped.
          if (beat_q == len_q && !s.wlast) over_d = 1'b1;
          if (s.wlast) begin
            werr_d  = werr_q || (beat_q != len_q) || over_q;
            state_d = WB;
          end
        end
      end
      WB: begin
        bvalid = 1'b1;
        if (s.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= '0;
      addr_q  <= 32'd0;
      len_q   <= 4'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      beat_q  <= 4'd0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      werr_q  <= werr_d;
      over_q  <= over_d;
    end
  end

  axi_ram_bytewe #(.MEM_AW(MEM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q[MEM_AW+1:2]),
    .wdata (s.wdata),
    .rdata (ram_rdata)
  );

  assign s.arready = arready;
  assign s.awready = awready;
  assign s.wready  = wready;
  assign s.rvalid  = rvalid;
  assign s.rlast   = rlast;
  assign s.bvalid  = bvalid;
  assign s.rid     = rvalid ? id_q : '0;
  assign s.rdata   = (rvalid && !err_q) ? ram_rdata : 32'd0;
  assign s.rresp   = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s.bid     = bvalid ? id_q : '0;
  assign s.bresp   = (bvalid && (err_q || werr_q)) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: bursts, arbitration, errors, mid-burst reset.
module tb_axi_ram_slave;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_ram_slave_if #(.ID_W(4)) bus ();

  axi_ram_slave #(.MEM_AW(14), .ID_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic aw_req(input int a, input int len, input int bt, input int sz, input int id);
    int n = 0;
    bus.awaddr = 32'(a); bus.awlen = 8'(len); bus.awburst = 2'(bt);
    bus.awsize = 3'(sz); bus.awid = 4'(id); bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && n < 20) begin settle(); n++; end
    chk("awready", 32'(bus.awready), 32'd1);
    settle();
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_req(input int a, input int len, input int bt, input int sz, input int id);
    int n = 0;
    bus.araddr = 32'(a); bus.arlen = 8'(len); bus.arburst = 2'(bt);
    bus.arsize = 3'(sz); bus.arid = 4'(id); bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 20) begin settle(); n++; end
    chk("arready", 32'(bus.arready), 32'd1);
    settle();
    bus.arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic l);
    int n = 0;
    bus.wdata = d; bus.wstrb = st; bus.wlast = l; bus.wvalid = 1'b1;
    #1;
    while (!bus.wready && n < 20) begin settle(); n++; end
    chk("wready", 32'(bus.wready), 32'd1);
    settle();
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_resp(input int resp, input int id);
    int n = 0;
    bus.bready = 1'b1;
    #1;
    while (!bus.bvalid && n < 20) begin settle(); n++; end
    chk("bvalid", 32'(bus.bvalid), 32'd1);
    chk("bresp", 32'(bus.bresp), 32'(resp));
    chk("bid", 32'(bus.bid), 32'(id));
    settle();
    bus.bready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] d, input int resp, input int last, input int id, input bit chkd);
    int n = 0;
    bus.rready = 1'b1;
    #1;
    while (!bus.rvalid && n < 20) begin settle(); n++; end
    chk("rvalid", 32'(bus.rvalid), 32'd1);
    if (chkd) chk("rdata", bus.rdata, d);
    chk("rresp", 32'(bus.rresp), 32'(resp));
    chk("rlast", 32'(bus.rlast), 32'(last));
    chk("rid", 32'(bus.rid), 32'(id));
    settle();
    bus.rready = 1'b0;
  endtask

  initial begin
    int n;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Reset state: every output low.
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_ids", 32'({bus.rid, bus.bid}), 32'd0);
    chk("rst_resps", 32'({bus.rresp, bus.bresp}), 32'd0);
    reset = 1'b0;
    settle();

    // W before AW is stalled.
    bus.wvalid = 1'b1; bus.wdata = 32'h5555_5555; bus.wstrb = 4'hF;
    #1;
    chk("w_stall", 32'(bus.wready), 32'd0);
    settle();
    bus.wvalid = 1'b0;

    // Round robin: first simultaneous pair goes to the read.
    bus.araddr = 32'h204; bus.arlen = 8'd0; bus.arburst = BURST_INCR; bus.arsize = 3'd2;
    bus.arid = 4'd3; bus.arvalid = 1'b1;
    bus.awaddr = 32'h204; bus.awlen = 8'd0; bus.awburst = BURST_INCR; bus.awsize = 3'd2;
    bus.awid = 4'd5; bus.awvalid = 1'b1;
    #1;
    chk("rr0_arready", 32'(bus.arready), 32'd1);
    chk("rr0_awready", 32'(bus.awready), 32'd0);
    settle();
    bus.arvalid = 1'b0;
    chk("rr0_aw_blocked", 32'(bus.awready), 32'd0);
    r_beat(32'd0, RESP_OKAY, 1, 3, 1'b0);
    // Second simultaneous pair goes to the write.
    bus.arvalid = 1'b1;
    #1;
    chk("rr1_awready", 32'(bus.awready), 32'd1);
    chk("rr1_arready", 32'(bus.arready), 32'd0);
    settle();
    bus.awvalid = 1'b0;
    w_beat(32'h0BAD_F00D, 4'hF, 1'b1);
    b_resp(RESP_OKAY, 5);
    chk("rr2_arready", 32'(bus.arready), 32'd1);
    settle();
    bus.arvalid = 1'b0;
    r_beat(32'h0BAD_F00D, RESP_OKAY, 1, 3, 1'b1);

    // Single write then read, with first-rvalid latency.
    aw_req(32'h10, 0, BURST_INCR, 2, 1);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    b_resp(RESP_OKAY, 1);
    ar_req(32'h10, 0, BURST_INCR, 2, 2);
    chk("lat_cycle1", 32'(bus.rvalid), 32'd0);
    settle();
    chk("lat_cycle2", 32'(bus.rvalid), 32'd1);
    r_beat(32'hDEAD_BEEF, RESP_OKAY, 1, 2, 1'b1);

    // INCR burst of 4, readback with rready stalls.
    aw_req(32'h100, 3, BURST_INCR, 2, 6);
    for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
    b_resp(RESP_OKAY, 6);
    ar_req(32'h100, 3, BURST_INCR, 2, 7);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      bus.rready = 1'b0;
      #1;
      while (!bus.rvalid && n < 20) begin settle(); n++; end
      chk("incr_data", bus.rdata, 32'(i + 1));
      chk("incr_rlast", 32'(bus.rlast), 32'(i == 3));
      settle();
      chk("incr_hold_valid", 32'(bus.rvalid), 32'd1);
      chk("incr_hold_data", bus.rdata, 32'(i + 1));
      bus.rready = 1'b1;
      settle();
      bus.rready = 1'b0;
    end

    // WRAP len3 at 0x38 lands on 0x38,0x3C,0x30,0x34.
    aw_req(32'h38, 3, BURST_WRAP, 2, 1);
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), 4'hF, i == 3);
    b_resp(RESP_OKAY, 1);
    ar_req(32'h30, 3, BURST_INCR, 2, 1);
    r_beat(32'hA2, RESP_OKAY, 0, 1, 1'b1);
    r_beat(32'hA3, RESP_OKAY, 0, 1, 1'b1);
    r_beat(32'hA0, RESP_OKAY, 0, 1, 1'b1);
    r_beat(32'hA1, RESP_OKAY, 1, 1, 1'b1);
    ar_req(32'h38, 3, BURST_WRAP, 2, 2);
    for (int i = 0; i < 4; i++) r_beat(32'hA0 + 32'(i), RESP_OKAY, int'(i == 3), 2, 1'b1);

    // FIXED len3 at 0x40 hits only 0x40; 0x44 keeps its value.
    aw_req(32'h44, 0, BURST_INCR, 2, 2);
    w_beat(32'h4444_4444, 4'hF, 1'b1);
    b_resp(RESP_OKAY, 2);
    aw_req(32'h40, 3, BURST_FIXED, 2, 2);
    for (int i = 0; i < 4; i++) w_beat(32'hB0 + 32'(i), 4'hF, i == 3);
    b_resp(RESP_OKAY, 2);
    ar_req(32'h40, 1, BURST_FIXED, 2, 2);
    r_beat(32'hB3, RESP_OKAY, 0, 2, 1'b1);
    r_beat(32'hB3, RESP_OKAY, 1, 2, 1'b1);
    ar_req(32'h44, 0, BURST_INCR, 2, 2);
    r_beat(32'h4444_4444, RESP_OKAY, 1, 2, 1'b1);

    // Partial strobe merge.
    aw_req(32'h20, 0, BURST_INCR, 2, 3);
    w_beat(32'h1122_3344, 4'hF, 1'b1);
    b_resp(RESP_OKAY, 3);
    aw_req(32'h20, 0, BURST_INCR, 2, 3);
    w_beat(32'hAABB_CCDD, 4'h3, 1'b1);
    b_resp(RESP_OKAY, 3);
    ar_req(32'h20, 0, BURST_INCR, 2, 3);
    r_beat(32'h1122_CCDD, RESP_OKAY, 1, 3, 1'b1);

    // Illegal burst type / size.
    ar_req(32'h10, 1, 3, 2, 4);
    r_beat(32'd0, RESP_SLVERR, 0, 4, 1'b1);
    r_beat(32'd0, RESP_SLVERR, 1, 4, 1'b1);
    ar_req(32'h10, 0, BURST_INCR, 3, 4);
    r_beat(32'd0, RESP_SLVERR, 1, 4, 1'b1);
    aw_req(32'h10, 0, 3, 2, 5);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    b_resp(RESP_SLVERR, 5);
    ar_req(32'h10, 0, BURST_INCR, 2, 5);
    r_beat(32'hDEAD_BEEF, RESP_OKAY, 1, 5, 1'b1);

    // Early wlast on beat 2 of len3.
    aw_req(32'h80, 3, BURST_INCR, 2, 9);
    w_beat(32'd1, 4'hF, 1'b0);
    w_beat(32'd2, 4'hF, 1'b1);
    b_resp(RESP_SLVERR, 9);

    // Overrun: extra beat is dropped and flagged.
    aw_req(32'h64, 0, BURST_INCR, 2, 10);
    w_beat(32'h6464_6464, 4'hF, 1'b1);
    b_resp(RESP_OKAY, 10);
    aw_req(32'h60, 0, BURST_INCR, 2, 10);
    w_beat(32'h6060_6060, 4'hF, 1'b0);
    w_beat(32'hEEEE_EEEE, 4'hF, 1'b1);
    b_resp(RESP_SLVERR, 10);
    ar_req(32'h60, 1, BURST_INCR, 2, 10);
    r_beat(32'h6060_6060, RESP_OKAY, 0, 10, 1'b1);
    r_beat(32'h6464_6464, RESP_OKAY, 1, 10, 1'b1);

    // Reset during beat 2 of a 4-beat read.
    ar_req(32'h100, 3, BURST_INCR, 2, 11);
    r_beat(32'd1, RESP_OKAY, 0, 11, 1'b1);
    n = 0;
    #1;
    while (!bus.rvalid && n < 20) begin settle(); n++; end
    chk("mid_beat2", bus.rdata, 32'd2);
    reset = 1'b1;
    settle();
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    settle();
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    ar_req(32'h10, 0, BURST_INCR, 2, 12);
    r_beat(32'hDEAD_BEEF, RESP_OKAY, 1, 12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
